// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel timing from an hsync/vsync/de stream on the
// pixel clock. Produces active-pixel coordinates, line/frame strobes, the
// measured raw timing and a lock flag.
//
// Optional feature: define VGA_RX_ERR_CNT_EN to build a saturating 8-bit
// lock-loss counter on err_cnt. Without it err_cnt is tied to zero.
//
// state_dbg exposes the recovery FSM (SEARCH/MEASURE/LOCKED) for debug.
module vga_timing_rx #(
    parameter int CW      = 12,
    parameter int TIMEOUT = 4095
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          de,
    output logic [9:0]    x,
    output logic [9:0]    y,
    output logic          pix_valid,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_active,
    output logic          locked,
    output logic [7:0]    err_cnt,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

    state_t        state, state_nxt;

    logic          hs_q, hs_qq, vs_q, vs_qq, de_q, de_qq;
    logic          hs_fall, vs_fall, de_rise, de_fall;

    logic [CW-1:0] hcnt;      // clocks since the last hsync falling edge
    logic [CW-1:0] line_len;  // length of the most recent complete line
    logic [CW-1:0] de_run;    // de-high clocks in the current line
    logic [CW-1:0] lcnt;      // hsync falls since the last vsync fall
    logic [CW-1:0] dlcnt;     // de falls since the last vsync fall
    logic          line_bad;  // a line in this frame differed from its predecessor
    logic          have_ref;  // the previous frame was complete and clean

    logic [CW-1:0] new_len, len_now, lines_now, dlines_now;
    logic          bad_now, frame_match, timeout, meas_en;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // Edge detectors; syncs idle high so reset leaves no false edge.
    assign hs_fall = hs_qq & ~hs_q;
    assign vs_fall = vs_qq & ~vs_q;
    assign de_rise = de_q & ~de_qq;
    assign de_fall = de_qq & ~de_q;

    // Values as they stand once this cycle's hsync/de edge is accounted for,
    // so a coincident vsync fall sees the line that just ended.
    assign new_len     = sat_inc(hcnt);
    assign len_now     = hs_fall ? new_len : line_len;
    assign lines_now   = hs_fall ? sat_inc(lcnt) : lcnt;
    assign dlines_now  = de_fall ? sat_inc(dlcnt) : dlcnt;
    assign bad_now     = line_bad | (hs_fall & (new_len != line_len));
    assign frame_match = have_ref & ~bad_now &
                         (lines_now == v_total) & (len_now == h_total);
    assign timeout     = (hcnt >= TO_VAL);
    assign meas_en     = (state != SEARCH);

    assign locked    = (state == LOCKED);
    assign state_dbg = state;

    // Two-stage input registers feeding the edge detectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= 1'b1;
            hs_qq <= 1'b1;
            vs_q  <= 1'b1;
            vs_qq <= 1'b1;
            de_q  <= 1'b0;
            de_qq <= 1'b0;
        end else begin
            hs_q  <= hsync;
            hs_qq <= hs_q;
            vs_q  <= vsync;
            vs_qq <= vs_q;
            de_q  <= de;
            de_qq <= de_q;
        end
    end

    // Pixel coordinates and strobes, two clocks behind the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= de_q;
            line_start  <= de_rise;
            frame_start <= vs_fall;
            if (de_rise) begin
                x <= '0;
            end else if (de_q) begin
                x <= x + 10'd1;
            end
            if (vs_fall) begin
                y <= '0;
            end else if (de_fall) begin
                y <= y + 10'd1;
            end
        end
    end

    // Line-level counters: line length, de run length, bad-line flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt     <= '0;
            line_len <= '0;
            de_run   <= '0;
            line_bad <= 1'b0;
        end else begin
            if (hs_fall) begin
                hcnt     <= '0;
                line_len <= new_len;
            end else begin
                hcnt <= sat_inc(hcnt);
            end
            if (de_rise) begin
                de_run <= {{(CW-1){1'b0}}, 1'b1};
            end else if (de_q) begin
                de_run <= sat_inc(de_run);
            end
            if (vs_fall) begin
                line_bad <= 1'b0;
            end else if (hs_fall && (new_len != line_len)) begin
                line_bad <= 1'b1;
            end
        end
    end

    // Frame-level counters and the published measurements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt     <= '0;
            dlcnt    <= '0;
            have_ref <= 1'b0;
            h_total  <= '0;
            v_total  <= '0;
            h_active <= '0;
            v_active <= '0;
        end else begin
            if (vs_fall) begin
                lcnt  <= '0;
                dlcnt <= '0;
            end else begin
                lcnt  <= lines_now;
                dlcnt <= dlines_now;
            end
            // A reference frame only counts if it was measured out of SEARCH
            // and contained no irregular line.
            if (timeout || !meas_en) begin
                have_ref <= 1'b0;
            end else if (vs_fall) begin
                have_ref <= ~bad_now;
            end
            if (meas_en && vs_fall) begin
                h_total  <= len_now;
                v_total  <= lines_now;
                v_active <= dlines_now;
            end
            if (meas_en && de_fall) begin
                h_active <= de_run;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: timeout wins, otherwise decide at each frame boundary.
    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = SEARCH;
        end else if (vs_fall) begin
            case (state)
                SEARCH:  state_nxt = MEASURE;
                MEASURE: state_nxt = frame_match ? LOCKED : MEASURE;
                LOCKED:  state_nxt = frame_match ? LOCKED : MEASURE;
                default: state_nxt = SEARCH;
            endcase
        end
    end

`ifdef VGA_RX_ERR_CNT_EN
    // Count every exit from LOCKED, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if ((state == LOCKED) && (state_nxt != LOCKED) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx: random small video modes, a shortened line,
// an hsync timeout, an asynchronous mid-line reset with the clock stopped,
// and repeated lock losses to reach the err_cnt saturation point.
`timescale 1ns/1ps
module tb_vga_timing_rx;

    localparam int CW      = 12;
    localparam int TIMEOUT = 100;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic clk_en = 1'b1;
    logic rst_n  = 1'b0;
    logic hsync  = 1'b1;
    logic vsync  = 1'b1;
    logic de     = 1'b0;

    logic [9:0]    x, y;
    logic          pix_valid, line_start, frame_start, locked;
    logic [CW-1:0] h_total, v_total, h_active, v_active;
    logic [7:0]    err_cnt;
    logic [1:0]    state_dbg;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    vga_timing_rx #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .pix_valid   (pix_valid),
        .line_start  (line_start),
        .frame_start (frame_start),
        .h_total     (h_total),
        .v_total     (v_total),
        .h_active    (h_active),
        .v_active    (v_active),
        .locked      (locked),
        .err_cnt     (err_cnt),
        .state_dbg   (state_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, ht, vt;

    typedef struct {
        int lines;
        int len;
        bit clean;
    } frame_t;

    frame_t     hist[$];
    bit         searching;
    bit         exp_locked;
    int         losses;
    int         cur_lines;
    bit         cur_clean;
    logic [19:0] exp_q[$];   // expected {y, x} of each active pixel

    int   ls_cnt, fs_cnt;
    logic lock_at_fs;

    function automatic int exp_err();
`ifdef VGA_RX_ERR_CNT_EN
        return (losses > 255) ? 255 : losses;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        searching  = 1;
        hist.delete();
        exp_locked = 0;
        losses     = 0;
        cur_lines  = 0;
        cur_clean  = 1;
    endtask

    // Frame boundary: locked means the last two complete frames were clean
    // and identical in size.
    task automatic model_vs();
        frame_t f;
        bit     nl;
        if (searching) begin
            searching = 0;
        end else begin
            f.lines = cur_lines;
            f.len   = ht;
            f.clean = cur_clean;
            hist.push_back(f);
            if (hist.size() > 2) void'(hist.pop_front());
            nl = 0;
            if (hist.size() == 2)
                nl = hist[0].clean && hist[1].clean &&
                     (hist[0].lines == hist[1].lines) && (hist[0].len == hist[1].len);
            if (exp_locked && !nl) losses++;
            exp_locked = nl;
        end
        cur_lines = 0;
        cur_clean = 1;
    endtask

    task automatic new_mode(input bit tiny);
        if (tiny) begin
            ha = 2; hfp = 2; hsw = 1; hbp = 1;
            va = 3; vfp = 1; vsw = 1; vbp = 1;
        end else begin
            ha  = $urandom_range(12, 4);
            hfp = $urandom_range(4, 2);
            hsw = $urandom_range(4, 2);
            hbp = $urandom_range(3, 1);
            va  = $urandom_range(8, 3);
            vfp = $urandom_range(3, 1);
            vsw = $urandom_range(2, 1);
            vbp = $urandom_range(3, 1);
        end
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        cur_clean = 0;   // the frame spanning a mode change has unequal lines
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_pixel(input int l, input int p, input bit hs_low, input bit vs_low, input bit d);
        @(negedge clk);
        hsync = ~hs_low;
        vsync = ~vs_low;
        de    = d;
        if (d) exp_q.push_back({10'(l), 10'(p)});
    endtask

    task automatic drive_line(input int l, input int len);
        for (int p = 0; p < len; p++)
            drive_pixel(l, p,
                        (p >= ha + hfp) && (p < ha + hfp + hsw),
                        (l >= va + vfp) && (l < va + vfp + vsw),
                        (l < va) && (p < ha));
    endtask

    task automatic check_meas();
        if (hist.size() > 0) begin
            check("h_total",  32'(h_total),  32'(hist[hist.size()-1].len));
            check("v_total",  32'(v_total),  32'(hist[hist.size()-1].lines));
            check("h_active", 32'(h_active), 32'(ha));
            check("v_active", 32'(v_active), 32'(va));
        end
    endtask

    // One full frame; short_line >= 0 drops one back-porch clock from that line.
    task automatic drive_frame(input int short_line);
        ls_cnt     = 0;
        fs_cnt     = 0;
        lock_at_fs = 1'bx;
        for (int l = 0; l < vt; l++) begin
            if (l == va + vfp) model_vs();
            if (l == short_line) cur_clean = 0;
            drive_line(l, (l == short_line) ? ht - 1 : ht);
            cur_lines++;
        end
        check("frame_start_cnt", 32'(fs_cnt), 32'd1);
        check("line_start_cnt",  32'(ls_cnt), 32'(va));
        check("locked_at_fs",    32'(lock_at_fs), 32'(exp_locked));
        check("locked",          32'(locked), 32'(exp_locked));
        check("err_cnt",         32'(err_cnt), 32'(exp_err()));
        check_meas();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"},           32'(x), 32'd0);
        check({tag, "_y"},           32'(y), 32'd0);
        check({tag, "_pix_valid"},   32'(pix_valid), 32'd0);
        check({tag, "_line_start"},  32'(line_start), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_h_total"},     32'(h_total), 32'd0);
        check({tag, "_v_total"},     32'(v_total), 32'd0);
        check({tag, "_h_active"},    32'(h_active), 32'd0);
        check({tag, "_v_active"},    32'(v_active), 32'd0);
        check({tag, "_locked"},      32'(locked), 32'd0);
        check({tag, "_err_cnt"},     32'(err_cnt), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                check("pix_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check("pixel_yx", 32'({y, x}), 32'(exp_q.pop_front()));
            end
            if (line_start) begin
                ls_cnt++;
                check("line_start_x0", 32'({pix_valid, x}), 32'({1'b1, 10'd0}));
            end
            if (frame_start) begin
                fs_cnt++;
                lock_at_fs = locked;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #23;
        check_reset_vals("por");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) drive_pixel(0, 0, 0, 0, 0);

        // Acquire lock on a random mode: locked from the third frame boundary.
        new_mode(0);
        repeat (3) drive_frame(-1);

        // One short line breaks lock; two clean frames restore it.
        drive_frame(1);
        drive_frame(-1);
        drive_frame(-1);

        // hsync stuck high while locked: fall back to SEARCH.
        for (int i = 0; i < TIMEOUT + 5; i++) drive_pixel(0, 0, 0, 0, 0);
        if (exp_locked) losses++;
        exp_locked = 0;
        searching  = 1;
        hist.delete();
        check("timeout_locked",  32'(locked), 32'd0);
        check("timeout_err_cnt", 32'(err_cnt), 32'(exp_err()));

        // Reacquire on a fresh random mode.
        new_mode(0);
        repeat (3) drive_frame(-1);

        // Asynchronous reset mid-line with the clock stopped.
        drive_line(0, ht);
        drive_line(1, ht);
        drive_line(2, ha + 2);
        clk_en = 1'b0;
        #1;
        check("drained_before_reset", 32'(exp_q.size()), 32'd0);
        #3 rst_n = 1'b0;
        #2;
        check_reset_vals("async_rst");
        model_reset();
        #5 rst_n = 1'b1;
        #5 clk_en = 1'b1;
        repeat (3) drive_frame(-1);

        // Drive err_cnt toward saturation with repeated lock losses.
        new_mode(1);
        repeat (3) drive_frame(-1);
        repeat (300) begin
            drive_frame(1);
            drive_frame(-1);
            drive_frame(-1);
        end

        repeat (4) drive_pixel(0, 0, 0, 0, 0);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_err_cnt", 32'(err_cnt), 32'(exp_err()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Run-length guard.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no completion expected finish before 3 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
